// File: rtl/multicycle_controller.sv
// Multicycle control FSM for an RV32I-subset datapath (lw/sw/R/I/beq/jal).
// Optional retired-instruction counter: define MCC_RETIRE_CNT_EN.
module multicycle_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [4:0]  A1,
  output logic [4:0]  A2,
  output logic [4:0]  A3,
  output logic        RegWrite,
  output logic        Illegal
`ifdef MCC_RETIRE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] RetireCount
`endif
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic is_lw, is_sw, is_r, is_i, is_beq, is_jal;
  logic [2:0] alu_op;
  logic f3_ok;

  assign opcode = Instr[6:0];
  assign funct3 = Instr[14:12];
  assign is_lw  = opcode == OP_LW;
  assign is_sw  = opcode == OP_SW;
  assign is_r   = opcode == OP_R;
  assign is_i   = opcode == OP_I;
  assign is_beq = opcode == OP_BEQ;
  assign is_jal = opcode == OP_JAL;

  assign A1 = Instr[19:15];
  assign A2 = Instr[24:20];
  assign A3 = Instr[11:7];

  logic unused_instr;
  assign unused_instr = ^{Instr[31], Instr[29:25]};

  always_comb begin
    alu_op = 3'b000;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_op = (is_r && Instr[30]) ? 3'b001 : 3'b000;
      3'b010:  alu_op = 3'b101;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      default: f3_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEMADR;
          is_r:         state_d = S_EXECR;
          is_i:         state_d = S_EXECI;
          is_beq:       state_d = S_BEQ;
          is_jal:       state_d = S_JAL;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR:   state_d = is_lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = f3_ok ? S_ALUWB : S_HALT;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  logic pcw, adr, mw, irw, rw;
  logic [1:0] rs, sa, sb, imm;
  logic [2:0] alu;

  always_comb begin
    pcw = 1'b0;
    adr = 1'b0;
    mw  = 1'b0;
    irw = 1'b0;
    rw  = 1'b0;
    rs  = 2'b00;
    sa  = 2'b00;
    sb  = 2'b00;
    alu = 3'b000;
    case (state_q)
      S_FETCH: begin
        irw = 1'b1;
        pcw = 1'b1;
        sb  = 2'b10;
        rs  = 2'b10;
      end
      S_DECODE: begin
        sa = 2'b01;
        sb = 2'b01;
      end
      S_MEMADR: begin
        sa = 2'b10;
        sb = 2'b01;
      end
      S_MEMREAD: adr = 1'b1;
      S_MEMWB: begin
        rs = 2'b01;
        rw = 1'b1;
      end
      S_MEMWRITE: begin
        adr = 1'b1;
        mw  = 1'b1;
      end
      S_EXECR: begin
        sa  = 2'b10;
        alu = alu_op;
      end
      S_EXECI: begin
        sa  = 2'b10;
        sb  = 2'b01;
        alu = alu_op;
      end
      S_ALUWB: rw = 1'b1;
      S_BEQ: begin
        sa  = 2'b10;
        alu = 3'b001;
        pcw = Zero;
      end
      S_JAL: begin
        sa  = 2'b01;
        sb  = 2'b10;
        pcw = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm = 2'b00;
    unique case (1'b1)
      is_sw:   imm = 2'b01;
      is_beq:  imm = 2'b10;
      is_jal:  imm = 2'b11;
      default: imm = 2'b00;
    endcase
  end

  // Enables are masked while rst is high even though state is already FETCH.
  assign PCWrite    = pcw & ~rst;
  assign IRWrite    = irw & ~rst;
  assign MemWrite   = mw & ~rst;
  assign RegWrite   = rw & (A3 != 5'd0) & ~rst;
  assign Illegal    = (state_q == S_HALT) & ~rst;
  assign AdrSrc     = adr;
  assign ResultSrc  = rs;
  assign ALUSrcA    = sa;
  assign ALUSrcB    = sb;
  assign ALUControl = alu;
  assign ImmSrc     = imm;

`ifdef MCC_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic retire;

  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                  (state_q == S_ALUWB) || (state_q == S_BEQ);
  assign cnt_d  = retire ? cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign RetireCount = cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule
